// File: rtl/cluster_pwr_seq.sv
// rtl/cluster_pwr_seq.sv - cluster power/boot sequencer
//
// Steps the cluster through power-up, clock start, reset release, isolation
// release and run. On power-off it drains the cluster, then re-asserts reset
// and removes the clock and power. Commands arrive over a valid/ready
// handshake. Ready is high only in OFF and RUN.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_on_i                 1 = power on, 0 = power off
//   cmd_boot_addr_i          boot address, latched on an accepted power-on
//   cluster_busy_i           cluster busy, observed only while draining
//   cluster_*_o              registered cluster control outputs
//   done_o                   one-cycle pulse on command completion
//   timeout_o                sticky drain-timeout flag
//   state_o                  current state encoding
module cluster_pwr_seq #(
    parameter int unsigned PWR_UP_CYCLES    = 16,
    parameter int unsigned RST_CYCLES       = 8,
    parameter int unsigned ISO_CYCLES       = 4,
    parameter int unsigned BUSY_IDLE_CYCLES = 4,
    parameter int unsigned DRAIN_TIMEOUT    = 1024,
    parameter int unsigned PWR_DN_CYCLES    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_on_i,
    input  logic [63:0] cmd_boot_addr_i,
    input  logic        cluster_busy_i,
    output logic        cluster_pow_o,
    output logic        cluster_byp_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic        done_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWR_UP     = 3'd1,
        ST_CLK_EN     = 3'd2,
        ST_RST_REL    = 3'd3,
        ST_RUN        = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_RST_ASSERT = 3'd6,
        ST_PWR_DN     = 3'd7
    } state_e;

    localparam int unsigned M0 = (PWR_UP_CYCLES > RST_CYCLES) ? PWR_UP_CYCLES : RST_CYCLES;
    localparam int unsigned M1 = (ISO_CYCLES > BUSY_IDLE_CYCLES) ? ISO_CYCLES : BUSY_IDLE_CYCLES;
    localparam int unsigned M2 = (DRAIN_TIMEOUT > PWR_DN_CYCLES) ? DRAIN_TIMEOUT : PWR_DN_CYCLES;
    localparam int unsigned M3 = (M0 > M1) ? M0 : M1;
    localparam int unsigned MAX_P = (M3 > M2) ? M3 : M2;
    localparam int W = $clog2(MAX_P + 1);

    localparam logic [W-1:0] PWR_UP_LD = W'(PWR_UP_CYCLES - 1);
    localparam logic [W-1:0] RST_LD    = W'(RST_CYCLES - 1);
    localparam logic [W-1:0] ISO_LD    = W'(ISO_CYCLES - 1);
    localparam logic [W-1:0] PWR_DN_LD = W'(PWR_DN_CYCLES - 1);
    localparam logic [W-1:0] IDLE_LAST = W'(BUSY_IDLE_CYCLES - 1);
    localparam logic [W-1:0] TMO_LAST  = W'(DRAIN_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  idle_q, idle_d;
    logic [W-1:0]  tmo_q, tmo_d;
    logic [63:0]   boot_q, boot_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    // {pow, byp, clk_en, rstn, fetch_en}
    logic [4:0]    out_q, out_d;
    logic          accept;
    logic          cnt_zero;

    assign cmd_ready_o = (state_q == ST_OFF) || (state_q == ST_RUN);
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign cnt_zero    = (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_zero ? cnt_q : cnt_q - 1'b1;
        idle_d    = idle_q;
        tmo_d     = tmo_q;
        boot_d    = boot_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        case (state_q)
            ST_OFF: begin
                if (accept) begin
                    if (cmd_on_i) begin
                        boot_d    = cmd_boot_addr_i;
                        timeout_d = 1'b0;
                        state_d   = ST_PWR_UP;
                        cnt_d     = PWR_UP_LD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_PWR_UP: if (cnt_zero) begin
                state_d = ST_CLK_EN;
                cnt_d   = RST_LD;
            end
            ST_CLK_EN: if (cnt_zero) begin
                state_d = ST_RST_REL;
                cnt_d   = ISO_LD;
            end
            ST_RST_REL: if (cnt_zero) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end
            ST_RUN: begin
                if (accept) begin
                    if (cmd_on_i) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DRAIN;
                        idle_d  = '0;
                        tmo_d   = '0;
                    end
                end
            end
            ST_DRAIN: begin
                idle_d = cluster_busy_i ? '0 : idle_q + 1'b1;
                tmo_d  = tmo_q + 1'b1;
                // Idle completion takes priority over a coincident timeout.
                if (!cluster_busy_i && (idle_q == IDLE_LAST)) begin
                    state_d = ST_RST_ASSERT;
                    cnt_d   = RST_LD;
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = ST_RST_ASSERT;
                    cnt_d     = RST_LD;
                    timeout_d = 1'b1;
                end
            end
            ST_RST_ASSERT: if (cnt_zero) begin
                state_d = ST_PWR_DN;
                cnt_d   = PWR_DN_LD;
            end
            ST_PWR_DN: if (cnt_zero) begin
                state_d = ST_OFF;
                done_d  = 1'b1;
            end
            default: state_d = ST_OFF;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as state_o.
    always_comb begin
        out_d = 5'b01000;
        case (state_d)
            ST_OFF:        out_d = 5'b01000;
            ST_PWR_UP:     out_d = 5'b11000;
            ST_CLK_EN:     out_d = 5'b11100;
            ST_RST_REL:    out_d = 5'b11110;
            ST_RUN:        out_d = 5'b10111;
            ST_DRAIN:      out_d = 5'b10110;
            ST_RST_ASSERT: out_d = 5'b11100;
            ST_PWR_DN:     out_d = 5'b11000;
            default:       out_d = 5'b01000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            idle_q    <= '0;
            tmo_q     <= '0;
            boot_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            out_q     <= 5'b01000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idle_q    <= idle_d;
            tmo_q     <= tmo_d;
            boot_q    <= boot_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            out_q     <= out_d;
        end
    end

    assign cluster_pow_o          = out_q[4];
    assign cluster_byp_o          = out_q[3];
    assign cluster_clk_en_o       = out_q[2];
    assign cluster_rstn_o         = out_q[1];
    assign cluster_fetch_enable_o = out_q[0];
    assign cluster_boot_addr_o    = boot_q;
    assign done_o                 = done_q;
    assign timeout_o              = timeout_q;
    assign state_o                = state_q;

endmodule
